// File: rtl/display_select_n.sv
// display_select_n
//   Registered selector that routes one of NCH channel sources (an LED vector
//   plus NHEX active-low seven-segment bytes) to the board LED bar and HEX
//   digits. The channel is picked manually from `sel`, or rotated
//   automatically on a dwell timer and on a debounced push-button step. Every
//   channel change blanks the displays for BLANK_CYC cycles, so the board
//   never shows half-switched data.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   ch_leds    NCH*LED_W source LEDs; channel c at [c*LED_W +: LED_W]
//   ch_hex     NCH*NHEX*8 source digits; channel c at [c*NHEX*8 +: NHEX*8]
//   sel        manual channel select; values >= NCH are ignored
//   auto_en    1 = auto-rotate, 0 = manual
//   key_n      raw asynchronous push-button, active-low
//   LEDR       registered selected LEDs (all 0 while blanking)
//   HEX        registered selected digits, HEX0 at [7:0] (all 1 while blanking)
//   cur_ch     current channel index
//   ch_change  one-cycle pulse in the first cycle cur_ch holds a new value
module display_select_n #(
  parameter int NCH          = 4,
  parameter int LED_W        = 10,
  parameter int NHEX         = 6,
  parameter int SEL_W        = $clog2(NCH),
  parameter int DWELL_CYC    = 50_000_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int BLANK_CYC    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*LED_W-1:0]  ch_leds,
  input  logic [NCH*NHEX*8-1:0] ch_hex,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  auto_en,
  input  logic                  key_n,
  output logic [LED_W-1:0]      LEDR,
  output logic [NHEX*8-1:0]     HEX,
  output logic [SEL_W-1:0]      cur_ch,
  output logic                  ch_change
);

  localparam int DW_W = $clog2(DWELL_CYC);
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int BL_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [BL_W-1:0]  BLANK_LOAD = BL_W'(BLANK_CYC);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(NCH - 1);
  localparam logic [SEL_W:0]   NCH_V      = (SEL_W + 1)'(NCH);

  typedef enum logic {SHOW, BLANK} state_t;

  // ---------------------------------------------------------------------------
  // Source unpacking: one array entry per channel keeps the output mux simple.
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0]  led_src [NCH];
  logic [NHEX*8-1:0] hex_src [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_src
      assign led_src[gi] = ch_leds[gi*LED_W +: LED_W];
      assign hex_src[gi] = ch_hex[gi*NHEX*8 +: NHEX*8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Key synchroniser and debouncer. The counter only runs while the synced
  // level disagrees with the accepted level, so any bounce back clears it.
  // ---------------------------------------------------------------------------
  logic            sync1_reg, sync2_reg, db_level_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            db_flip, step;

  assign db_flip = (sync2_reg != db_level_reg) && (db_cnt_reg == DB_LAST);
  // Only the press (accepted 1->0) steps; the release flip is silent.
  assign step    = db_flip && db_level_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      db_level_reg <= 1'b1;
      db_cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg == db_level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_flip) begin
        db_level_reg <= sync2_reg;
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel selection (manual or auto-rotate with dwell timer).
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] cur_ch_reg, cur_ch_next;
  logic [DW_W-1:0]  dwell_reg, dwell_next;
  logic             ch_change_reg;
  logic             ch_upd;

  always_comb begin
    cur_ch_next = cur_ch_reg;
    dwell_next  = '0;
    if (auto_en) begin
      // Expiry and step in the same cycle still advance only once.
      if ((dwell_reg == DWELL_LAST) || step) begin
        cur_ch_next = (cur_ch_reg == CH_LAST) ? '0 : cur_ch_reg + SEL_W'(1);
      end else begin
        dwell_next = dwell_reg + DW_W'(1);
      end
    end else if (({1'b0, sel} < NCH_V) && (sel != cur_ch_reg)) begin
      cur_ch_next = sel;
    end
  end

  assign ch_upd = (cur_ch_next != cur_ch_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ch_reg    <= '0;
      dwell_reg     <= '0;
      ch_change_reg <= 1'b0;
    end else begin
      cur_ch_reg    <= cur_ch_next;
      dwell_reg     <= dwell_next;
      ch_change_reg <= ch_upd;
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM. The update is taken from the same-cycle next-state, so the
  // edge that loads the new cur_ch also enters BLANK; the old channel is shown
  // for that one edge, then BLANK_CYC blank cycles, then the new channel.
  // ---------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [BL_W-1:0]   blank_reg, blank_next;
  logic [LED_W-1:0]  led_reg, led_next;
  logic [NHEX*8-1:0] hex_reg, hex_next;

  always_comb begin
    state_next = state_reg;
    blank_next = blank_reg;
    led_next   = led_src[cur_ch_reg];
    hex_next   = hex_src[cur_ch_reg];
    if (state_reg == BLANK) begin
      led_next   = '0;
      hex_next   = '1;
      blank_next = blank_reg - BL_W'(1);
      if (blank_reg == BL_W'(1)) begin
        state_next = SHOW;
      end
    end
    if (ch_upd) begin
      blank_next = BLANK_LOAD;
      if (BLANK_CYC > 0) begin
        state_next = BLANK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SHOW;
      blank_reg <= '0;
      led_reg   <= '0;
      hex_reg   <= '1;
    end else begin
      state_reg <= state_next;
      blank_reg <= blank_next;
      led_reg   <= led_next;
      hex_reg   <= hex_next;
    end
  end

  assign LEDR      = led_reg;
  assign HEX       = hex_reg;
  assign cur_ch    = cur_ch_reg;
  assign ch_change = ch_change_reg;

endmodule
